// File: rtl/rv32i_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single-word memory bus.
// One transaction in flight; handles lane placement, load extension, alignment errors and bus timeout.
module rv32i_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ready,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'd0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << off;
      3'b001:  s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Fetches are checked as word loads (funct3 010).
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic e;
    if (we) begin
      case (f3)
        3'b000:  e = 1'b0;
        3'b001:  e = off[0];
        3'b010:  e = (off != 2'b00);
        default: e = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: e = 1'b0;
        3'b001, 3'b101: e = off[0];
        3'b010:         e = (off != 2'b00);
        default:        e = 1'b1;
      endcase
    end
    return e;
  endfunction

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [3:0]        strb_q, strb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              grant_ls;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_f3;
  logic              sel_we;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    off_d        = off_q;
    f3_d         = f3_q;
    we_d         = we_q;
    strb_d       = strb_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    if_ready     = 1'b0;
    ls_ready     = 1'b0;

    // Under contention the requester not granted last time wins.
    grant_ls = ls_req && (!if_req || last_grant_q == GNT_IF);
    sel_addr = grant_ls ? ls_addr : if_addr;
    sel_f3   = grant_ls ? ls_funct3 : 3'b010;
    sel_we   = grant_ls && ls_we;

    case (state_q)
      IDLE: begin
        if_ready = !if_req || !grant_ls;
        ls_ready = !ls_req || grant_ls;
        if (if_req || ls_req) begin
          gnt_d        = grant_ls;
          last_grant_d = grant_ls;
          addr_d       = {sel_addr[ADDR_W-1:2], 2'b00};
          off_d        = sel_addr[1:0];
          f3_d         = sel_f3;
          we_d         = sel_we;
          strb_d       = sel_we ? store_strb(sel_f3, sel_addr[1:0]) : 4'b0000;
          wdata_d      = sel_we ? store_data(sel_f3, ls_wdata) : 32'd0;
          cnt_d        = '0;
          rdata_d      = 32'd0;
          if (access_err(sel_we, sel_f3, sel_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (mem_ready) begin
          err_d   = 1'b0;
          state_d = RESP;
          if (gnt_q == GNT_IF) rdata_d = mem_rdata;
          else if (we_q)       rdata_d = 32'd0;
          else                 rdata_d = load_ext(f3_q, off_q, mem_rdata);
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IF;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
    gnt_q   <= gnt_d;
    addr_q  <= addr_d;
    off_q   <= off_d;
    f3_q    <= f3_d;
    we_q    <= we_d;
    strb_q  <= strb_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
    err_q   <= err_d;
  end

  // Bus and response outputs are forced to zero outside their owning state.
  always_comb begin
    mem_req   = (state_q == BUS);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_req ? addr_q : '0;
    mem_wstrb = mem_req ? strb_q : 4'b0000;
    mem_wdata = mem_req ? wdata_q : 32'd0;
    if_valid  = (state_q == RESP) && (gnt_q == GNT_IF);
    ls_done   = (state_q == RESP) && (gnt_q == GNT_LS);
    if_rdata  = if_valid ? rdata_q : 32'd0;
    if_err    = if_valid && err_q;
    ls_rdata  = ls_done ? rdata_q : 32'd0;
    ls_err    = ls_done && err_q;
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: fetch, load/store lanes, errors, arbitration, timeout, reset.
module tb_rv32i_mem_arbiter;

  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_valid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_ready, ls_done, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load/store through the bus with one wait cycle before mem_ready.
  task automatic lsu_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd,
                         input logic [31:0] e_addr, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wd;
    #1;
    chk({tag, ".ls_ready"}, ls_ready, 1);
    step();
    ls_req = 1'b0;
    chk({tag, ".mem_req"}, mem_req, 1);
    chk({tag, ".mem_we"}, mem_we, we);
    chk({tag, ".mem_addr"}, mem_addr, e_addr);
    chk({tag, ".mem_wstrb"}, mem_wstrb, e_strb);
    chk({tag, ".mem_wdata"}, mem_wdata, e_wdata);
    step();
    chk({tag, ".hold_addr"}, mem_addr, e_addr);
    chk({tag, ".hold_wdata"}, mem_wdata, e_wdata);
    mem_ready = 1'b1; mem_rdata = mrd;
    step();
    mem_ready = 1'b0;
    chk({tag, ".ls_done"}, ls_done, 1);
    chk({tag, ".ls_rdata"}, ls_rdata, e_rdata);
    chk({tag, ".ls_err"}, ls_err, 0);
    chk({tag, ".resp_mem_req"}, mem_req, 0);
    step();
    chk({tag, ".ls_done_end"}, ls_done, 0);
  endtask

  // Request that must be rejected without a bus cycle.
  task automatic lsu_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
    ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = 32'hFFFF_FFFF;
    step();
    ls_req = 1'b0;
    chk({tag, ".mem_req"}, mem_req, 0);
    chk({tag, ".ls_done"}, ls_done, 1);
    chk({tag, ".ls_err"}, ls_err, 1);
    chk({tag, ".ls_rdata"}, ls_rdata, 0);
    step();
    chk({tag, ".ls_done_end"}, ls_done, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_funct3 = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    chk("rst.mem_req", mem_req, 0);
    chk("rst.if_valid", if_valid, 0);
    chk("rst.ls_done", ls_done, 0);
    chk("rst.mem_wstrb", mem_wstrb, 0);
    reset = 1'b0;
    step();
    chk("rst.if_ready", if_ready, 1);
    chk("rst.ls_ready", ls_ready, 1);

    // Basic fetch with minimum latency.
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("fetch.if_ready", if_ready, 1);
    step();
    if_req = 1'b0;
    chk("fetch.mem_req", mem_req, 1);
    chk("fetch.mem_addr", mem_addr, 32'h100);
    chk("fetch.mem_we", mem_we, 0);
    chk("fetch.mem_wstrb", mem_wstrb, 0);
    chk("fetch.busy_ready", if_ready, 0);
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    step();
    mem_ready = 1'b0;
    chk("fetch.if_valid", if_valid, 1);
    chk("fetch.if_rdata", if_rdata, 32'h0050_0093);
    chk("fetch.if_err", if_err, 0);
    chk("fetch.ls_done", ls_done, 0);
    chk("fetch.resp_mem_req", mem_req, 0);
    step();
    chk("fetch.if_valid_end", if_valid, 0);
    chk("fetch.if_rdata_end", if_rdata, 0);
    chk("fetch.if_ready_back", if_ready, 1);

    // Loads.
    lsu_txn("lb",  1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_FFFF, 32'h200, 4'b0000, 32'h0, 32'hFFFF_FF80);
    lsu_txn("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_FFFF, 32'h200, 4'b0000, 32'h0, 32'h0000_0080);
    lsu_txn("lh",  1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_5A5A, 32'h200, 4'b0000, 32'h0, 32'hFFFF_8001);
    lsu_txn("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 32'h8001_5A5A, 32'h200, 4'b0000, 32'h0, 32'h0000_8001);
    lsu_txn("lb0", 1'b0, 3'b000, 32'h210, 32'h0, 32'h1234_567F, 32'h210, 4'b0000, 32'h0, 32'h0000_007F);
    lsu_txn("lw",  1'b0, 3'b010, 32'h204, 32'h0, 32'hCAFE_F00D, 32'h204, 4'b0000, 32'h0, 32'hCAFE_F00D);

    // Stores.
    lsu_txn("sb",  1'b1, 3'b000, 32'h101, 32'h0000_00AB, 32'h1111_1111, 32'h100, 4'b0010, 32'hABAB_ABAB, 32'h0);
    lsu_txn("sh",  1'b1, 3'b001, 32'h102, 32'h0000_1234, 32'h1111_1111, 32'h100, 4'b1100, 32'h1234_1234, 32'h0);
    lsu_txn("sh0", 1'b1, 3'b001, 32'h108, 32'hFFFF_BEEF, 32'h1111_1111, 32'h108, 4'b0011, 32'hBEEF_BEEF, 32'h0);
    lsu_txn("sw",  1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h1111_1111, 32'h104, 4'b1111, 32'hDEAD_BEEF, 32'h0);

    // Misaligned / illegal accesses.
    lsu_err("lw_mis", 1'b0, 3'b010, 32'h102);
    lsu_err("lh_mis", 1'b0, 3'b001, 32'h201);
    lsu_err("sh_mis", 1'b1, 3'b001, 32'h203);
    lsu_err("ld_f3",  1'b0, 3'b110, 32'h200);
    lsu_err("st_f3",  1'b1, 3'b100, 32'h200);
    if_req = 1'b1; if_addr = 32'h102;
    step();
    if_req = 1'b0;
    chk("fetch_mis.mem_req", mem_req, 0);
    chk("fetch_mis.if_valid", if_valid, 1);
    chk("fetch_mis.if_err", if_err, 1);
    step();

    // Contention three times: LSU, IF, LSU.
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h400;
    #1;
    chk("arb1.ls_ready", ls_ready, 1);
    chk("arb1.if_ready", if_ready, 0);
    step();
    ls_req = 1'b0;
    chk("arb1.mem_addr", mem_addr, 32'h400);
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_0001;
    step();
    mem_ready = 1'b0;
    chk("arb1.ls_done", ls_done, 1);
    chk("arb1.mem_req", mem_req, 0);
    step();
    ls_req = 1'b1;
    #1;
    chk("arb2.if_ready", if_ready, 1);
    chk("arb2.ls_ready", ls_ready, 0);
    step();
    if_req = 1'b0;
    chk("arb2.mem_addr", mem_addr, 32'h300);
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_0002;
    step();
    mem_ready = 1'b0;
    chk("arb2.if_valid", if_valid, 1);
    chk("arb2.if_rdata", if_rdata, 32'hAAAA_0002);
    chk("arb2.mem_req", mem_req, 0);
    step();
    if_req = 1'b1;
    #1;
    chk("arb3.ls_ready", ls_ready, 1);
    chk("arb3.if_ready", if_ready, 0);
    step();
    ls_req = 1'b0; if_req = 1'b0;
    chk("arb3.mem_addr", mem_addr, 32'h400);
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_0003;
    step();
    mem_ready = 1'b0;
    chk("arb3.ls_done", ls_done, 1);
    chk("arb3.ls_rdata", ls_rdata, 32'hAAAA_0003);
    step();

    // Stray mem_ready while idle must produce nothing.
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("stray.if_valid", if_valid, 0);
    chk("stray.ls_done", ls_done, 0);
    chk("stray.mem_req", mem_req, 0);

    // Bus timeout on a fetch.
    if_req = 1'b1; if_addr = 32'h500;
    step();
    if_req = 1'b0;
    n = 0;
    while (mem_req && n < TO + 5) begin
      n++;
      step();
    end
    chk("tmo.bus_cycles", n, TO);
    chk("tmo.if_valid", if_valid, 1);
    chk("tmo.if_err", if_err, 1);
    chk("tmo.if_rdata", if_rdata, 0);
    step();
    chk("tmo.if_valid_end", if_valid, 0);

    // Reset while in BUS abandons the transaction.
    if_req = 1'b1; if_addr = 32'h600;
    step();
    if_req = 1'b0;
    chk("rstbus.mem_req_before", mem_req, 1);
    reset = 1'b1;
    step();
    chk("rstbus.mem_req", mem_req, 0);
    chk("rstbus.if_valid", if_valid, 0);
    reset = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_ready = 1'b0;
    chk("rstbus.if_valid_late", if_valid, 0);
    chk("rstbus.ls_done_late", ls_done, 0);
    chk("rstbus.if_ready", if_ready, 1);
    chk("rstbus.ls_ready", ls_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
